// File: rtl/eight_input_pe_ii.sv
// Registered 8-to-3 priority encoder with valid flag (out3) and selectable priority direction.
// Optional 2-flop input synchronizer enabled by defining PE_INPUT_SYNC_EN.
module eight_input_pe_ii #(
  parameter bit PRIORITY_MSB = 1'b1  // 1: in7 wins, 0: in0 wins
) (
  input  logic clk,
  input  logic reset,
  input  logic in7,
  input  logic in6,
  input  logic in5,
  input  logic in4,
  input  logic in3,
  input  logic in2,
  input  logic in1,
  input  logic in0,
  output logic out3,
  output logic out2,
  output logic out1,
  output logic out0
);

  logic [7:0] req_raw;
  logic [7:0] req;
  logic       hit;
  logic [2:0] idx;
  logic [3:0] out_q;

  assign req_raw = {in7, in6, in5, in4, in3, in2, in1, in0};

`ifdef PE_INPUT_SYNC_EN
  logic [7:0] sync_q1;
  logic [7:0] sync_q2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= req_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign req = sync_q2;
`else
  assign req = req_raw;
`endif

  // The last matching line in scan order wins, so scan toward the highest-priority end.
  always_comb begin
    // NOTE: defaults first keep this purely combinational and force idx to 0 when nothing is requested.
    hit = 1'b0;
    idx = 3'd0;
    if (PRIORITY_MSB) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          hit = 1'b1;
          idx = i[2:0];
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (req[i]) begin
          hit = 1'b1;
          idx = i[2:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 4'b0000;
    end else begin
      out_q <= {hit, idx};
    end
  end

  assign {out3, out2, out1, out0} = out_q;

endmodule

// File: tb/tb_eight_input_pe_ii.sv
// Scoreboard bench for eight_input_pe_ii: one instance per priority direction sharing the same inputs.
// Expected latency follows PE_INPUT_SYNC_EN (3 cycles) or its absence (1 cycle).
module tb_eight_input_pe_ii;

`ifdef PE_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic reset;
  logic in7, in6, in5, in4, in3, in2, in1, in0;
  logic a3, a2, a1, a0;
  logic b3, b2, b1, b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] q_msb[$];
  logic [3:0] q_lsb[$];
  logic [3:0] last_msb;
  logic [3:0] last_lsb;
  bit         have_last = 1'b0;

  eight_input_pe_ii #(.PRIORITY_MSB(1'b1)) dut_msb (
    .clk(clk), .reset(reset),
    .in7(in7), .in6(in6), .in5(in5), .in4(in4),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .out3(a3), .out2(a2), .out1(a1), .out0(a0)
  );

  eight_input_pe_ii #(.PRIORITY_MSB(1'b0)) dut_lsb (
    .clk(clk), .reset(reset),
    .in7(in7), .in6(in6), .in5(in5), .in4(in4),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .out3(b3), .out2(b2), .out1(b1), .out0(b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_msb(input logic [7:0] v);
    int k;
    if (v == 8'd0) return 4'b0000;
    k = 0;
    while ((v >> (k + 1)) != 8'd0) k++;
    return {1'b1, 3'(k)};
  endfunction

  function automatic logic [3:0] model_lsb(input logic [7:0] v);
    int k;
    if (v == 8'd0) return 4'b0000;
    k = 0;
    while (v[k] == 1'b0) k++;
    return {1'b1, 3'(k)};
  endfunction

  // One clock cycle: drive at negedge, score at posedge, compare 1 time unit later.
  task automatic step(input string tag, input logic [7:0] v, input logic rst);
    logic [3:0] e_msb;
    logic [3:0] e_lsb;
    @(negedge clk);
    {in7, in6, in5, in4, in3, in2, in1, in0} = v;
    reset = rst;
    #1;
    if (have_last) begin
      check({tag, "/hold_msb"}, {a3, a2, a1, a0}, last_msb);
      check({tag, "/hold_lsb"}, {b3, b2, b1, b0}, last_lsb);
    end
    @(posedge clk);
    if (rst) begin
      q_msb.delete();
      q_lsb.delete();
      for (int i = 0; i < LAT; i++) begin
        q_msb.push_back(4'b0000);
        q_lsb.push_back(4'b0000);
      end
    end else begin
      q_msb.push_back(model_msb(v));
      q_lsb.push_back(model_lsb(v));
    end
    #1;
    if (q_msb.size() == 0 || q_lsb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/scoreboard: got empty queue expected pending entry", tag);
    end else begin
      e_msb = q_msb.pop_front();
      e_lsb = q_lsb.pop_front();
      check({tag, "/msb"}, {a3, a2, a1, a0}, e_msb);
      check({tag, "/lsb"}, {b3, b2, b1, b0}, e_lsb);
      last_msb  = e_msb;
      last_lsb  = e_lsb;
      have_last = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    {in7, in6, in5, in4, in3, in2, in1, in0} = 8'h00;

    // Reset dominates a full request vector, then release.
    step("reset", 8'hFF, 1'b1);
    step("reset", 8'hFF, 1'b1);
    for (int i = 0; i < LAT + 2; i++) step("release", 8'hFF, 1'b0);

    for (int v = 0; v < 256; v++) step("sweep", 8'(v), 1'b0);

    step("multi", 8'b0010_1010, 1'b0);
    step("multi", 8'b0010_1010, 1'b0);

    // Index must drop to zero, not hold, when requests vanish.
    step("clear", 8'b1000_0000, 1'b0);
    for (int i = 0; i < LAT + 1; i++) step("clear", 8'b0000_0000, 1'b0);

    for (int i = 0; i < LAT + 1; i++) step("midrst", 8'b0000_0100, 1'b0);
    step("midrst", 8'b0000_0100, 1'b1);
    for (int i = 0; i < LAT + 2; i++) step("midrst", 8'b0000_0100, 1'b0);

    for (int i = 0; i < LAT + 1; i++) step("stepin", 8'b0000_0000, 1'b0);
    for (int i = 0; i < LAT + 2; i++) step("stepin", 8'b0001_0000, 1'b0);

    for (int i = 0; i < 40; i++) step("random", 8'($urandom_range(0, 255)), 1'b0);

    for (int i = 0; i < LAT; i++) step("drain", 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
